// File: rtl/rot_tile_addr_gen.sv
// Tiled rotation address generator: walks an H x W source image in TILE x TILE
// tiles and emits one source/destination pixel-index pair per DMA beat.
module rot_tile_addr_gen #(
   parameter int DIM_W  = 16,
   parameter int ADDR_W = 32,
   parameter int TILE   = 8
) (
   input  logic              I_HCLK,
   input  logic              I_HRESET,
   input  logic              I_START,
   input  logic [DIM_W-1:0]  I_HEIGHT,
   input  logic [DIM_W-1:0]  I_WIDTH,
   input  logic              I_DIRECTION,
   input  logic [1:0]        I_DEGREES,
   input  logic              I_DMA_READY,
   output logic              O_VALID,
   output logic [ADDR_W-1:0] O_SRC_ADDR,
   output logic [ADDR_W-1:0] O_DST_ADDR,
   output logic              O_BUSY,
   output logic              O_DONE
);

   localparam int TW = (TILE > 1) ? $clog2(TILE) : 1;
   localparam logic [TW-1:0]    TILE_LAST = TW'(TILE - 1);
   localparam logic [DIM_W-1:0] TILE_STEP = DIM_W'(TILE);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [DIM_W-1:0] height_reg, height_next;
   logic [DIM_W-1:0] width_reg, width_next;
   logic [1:0]       k_reg, k_next;
   logic [DIM_W-1:0] tile_row_reg, tile_row_next;
   logic [DIM_W-1:0] tile_col_reg, tile_col_next;
   logic [TW-1:0]    in_row_reg, in_row_next;
   logic [TW-1:0]    in_col_reg, in_col_next;

   logic [DIM_W-1:0] row_cur, col_cur;
   logic [DIM_W-1:0] height_m1, width_m1;
   logic             col_end, row_end, at_last_col, at_last_row;
   logic             handshake;

   assign row_cur     = tile_row_reg + DIM_W'(in_row_reg);
   assign col_cur     = tile_col_reg + DIM_W'(in_col_reg);
   assign height_m1   = height_reg - DIM_W'(1);
   assign width_m1    = width_reg - DIM_W'(1);
   assign at_last_col = (col_cur == width_m1);
   assign at_last_row = (row_cur == height_m1);
   // A tile row/column ends either at the tile boundary or at the image edge.
   assign col_end     = (in_col_reg == TILE_LAST) || at_last_col;
   assign row_end     = (in_row_reg == TILE_LAST) || at_last_row;
   assign handshake   = (state_reg == S_RUN) && I_DMA_READY;

   always_ff @(posedge I_HCLK or posedge I_HRESET) begin
      if (I_HRESET) begin
         state_reg    <= S_IDLE;
         height_reg   <= '0;
         width_reg    <= '0;
         k_reg        <= '0;
         tile_row_reg <= '0;
         tile_col_reg <= '0;
         in_row_reg   <= '0;
         in_col_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         height_reg   <= height_next;
         width_reg    <= width_next;
         k_reg        <= k_next;
         tile_row_reg <= tile_row_next;
         tile_col_reg <= tile_col_next;
         in_row_reg   <= in_row_next;
         in_col_reg   <= in_col_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      height_next   = height_reg;
      width_next    = width_reg;
      k_next        = k_reg;
      tile_row_next = tile_row_reg;
      tile_col_next = tile_col_reg;
      in_row_next   = in_row_reg;
      in_col_next   = in_col_reg;
      case (state_reg)
         S_IDLE: begin
            if (I_START) begin
               height_next   = I_HEIGHT;
               width_next    = I_WIDTH;
               // CCW by d quarter turns equals CW by (4 - d) mod 4.
               k_next        = I_DIRECTION ? (2'd0 - I_DEGREES) : I_DEGREES;
               tile_row_next = '0;
               tile_col_next = '0;
               in_row_next   = '0;
               in_col_next   = '0;
               state_next    = ((I_HEIGHT == '0) || (I_WIDTH == '0)) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (handshake) begin
               if (!col_end) begin
                  in_col_next = in_col_reg + TW'(1);
               end else if (!row_end) begin
                  in_col_next = '0;
                  in_row_next = in_row_reg + TW'(1);
               end else begin
                  in_col_next = '0;
                  in_row_next = '0;
                  if (!at_last_col) begin
                     tile_col_next = tile_col_reg + TILE_STEP;
                  end else begin
                     tile_col_next = '0;
                     if (at_last_row) begin
                        tile_row_next = '0;
                        state_next    = S_DONE;
                     end else begin
                        tile_row_next = tile_row_reg + TILE_STEP;
                     end
                  end
               end
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   logic [ADDR_W-1:0] r_a, c_a, h_a, w_a;
   logic [ADDR_W-1:0] r_flip, c_flip;
   logic [ADDR_W-1:0] src_lin;
   logic [ADDR_W-1:0] dst_cand [4];

   assign r_a     = ADDR_W'(row_cur);
   assign c_a     = ADDR_W'(col_cur);
   assign h_a     = ADDR_W'(height_reg);
   assign w_a     = ADDR_W'(width_reg);
   assign r_flip  = h_a - ADDR_W'(1) - r_a;
   assign c_flip  = w_a - ADDR_W'(1) - c_a;
   assign src_lin = r_a * w_a + c_a;

   // One candidate destination per quarter-turn count, selected by k.
   for (genvar gi = 0; gi < 4; gi++) begin : g_dst
      if (gi == 0) begin : g_k0
         assign dst_cand[gi] = src_lin;
      end else if (gi == 1) begin : g_k1
         assign dst_cand[gi] = c_a * h_a + r_flip;
      end else if (gi == 2) begin : g_k2
         assign dst_cand[gi] = r_flip * w_a + c_flip;
      end else begin : g_k3
         assign dst_cand[gi] = c_flip * h_a + r_a;
      end
   end

   assign O_VALID    = (state_reg == S_RUN);
   assign O_BUSY     = (state_reg == S_RUN);
   assign O_DONE     = (state_reg == S_DONE);
   assign O_SRC_ADDR = O_VALID ? src_lin : '0;
   assign O_DST_ADDR = O_VALID ? dst_cand[k_reg] : '0;

endmodule

// File: doc/rot_tile_addr_gen.md
# rot_tile_addr_gen

Parametrised rotation address generator, successor to `core_pixel`. It walks a source image of I_HEIGHT×I_WIDTH pixels in TILE×TILE tiles and emits one source/destination pixel-index pair per DMA beat for 0/90/180/270° rotation in either direction. Partial edge tiles are supported, so dimensions need not be multiples of TILE. It sits between the config registers and the DMA read/write engines.

## Interface
Parameters:
- DIM_W, 16, width of the height/width inputs and the row/column counters.
- ADDR_W, 32, width of the pixel-index outputs. Results wrap modulo 2^ADDR_W.
- TILE, 8, tile edge in pixels. Power of two, at least 2.

Ports:
- I_HCLK  in  1  clock.
- I_HRESET  in  1  asynchronous, active-high reset.
- I_START  in  1  one-cycle start pulse. Sampled only in IDLE.
- I_HEIGHT  in  DIM_W  source rows (H).
- I_WIDTH  in  DIM_W  source columns (W).
- I_DIRECTION  in  1  0 = CW, 1 = CCW.
- I_DEGREES  in  2  0 = 0°, 1 = 90°, 2 = 180°, 3 = 270°.
- I_DMA_READY  in  1  consumer ready. Beat transfers when O_VALID && I_DMA_READY.
- O_VALID  out  1  address pair valid.
- O_SRC_ADDR  out  ADDR_W  source pixel index.
- O_DST_ADDR  out  ADDR_W  destination pixel index.
- O_BUSY  out  1  job in progress.
- O_DONE  out  1  one-cycle completion pulse.

## Operation
- States: IDLE → RUN → DONE → IDLE.
- IDLE, I_START=1:
  - Latch H, W and the effective quarter-turn count k. k = I_DEGREES for CW; k = (4 − I_DEGREES) mod 4 for CCW.
  - Clear the tile and in-tile counters.
  - If H==0 or W==0, go to DONE with zero beats. Otherwise go to RUN.
- Traversal order:
  - Tiles in row-major order. Within a tile, pixels in row-major order.
  - Edge tiles are truncated at row H−1 and column W−1. No out-of-image beats are issued.
- For the current source pixel (r,c):
  - O_SRC_ADDR = r·W + c.
  - O_DST_ADDR by k:
    - k=0: r·W + c.
    - k=1: c·H + (H−1−r).
    - k=2: (H−1−r)·W + (W−1−c).
    - k=3: (W−1−c)·H + r.
- Outputs are combinational from registered counters and latched config only. They do not depend on I_DMA_READY.
- RUN:
  - O_VALID=1.
  - Counters advance only on a handshake.
  - While stalled, both addresses hold stable.
  - A handshake on pixel (H−1,W−1) of the last tile moves the FSM to DONE.
- DONE lasts one cycle: O_DONE=1, O_BUSY=0, O_VALID=0. Then IDLE.
- O_BUSY=1 in RUN only.
- Config inputs and I_START are ignored outside IDLE.
- Total beats = H·W.

## Timing
- Reset values: O_VALID=0, O_BUSY=0, O_DONE=0, O_SRC_ADDR=0, O_DST_ADDR=0, state IDLE, counters 0.
- Reset is asynchronous. Asserting it mid-job aborts immediately: no O_DONE, outputs return to reset values.
- Start latency: I_START at edge n gives O_VALID=1 with the first pair valid during cycle n+1.
- Throughput: one beat per cycle with I_DMA_READY held high. This includes crossings between tiles and between tile rows.
- O_DONE is asserted in the cycle after the final handshake.
- I_START in the DONE cycle is ignored. It is accepted from the next (IDLE) cycle.
- Zero-dimension job: I_START at edge n gives O_DONE=1 in cycle n+1, and O_VALID never rises.

## Test plan
- 8×8, CW 90°, READY=1:
  - Beat 0: src 0 / dst 7. Beat 1: src 1 / dst 15.
  - Beat 63: src 63 / dst 56.
  - 64 beats total, O_DONE exactly one cycle after the last beat.
- H=6, W=10, TILE=8, 180°:
  - Beat 8 = (1,0): src 10 / dst 49.
  - Beat 48 = first pixel of tile 1, (0,8): src 8 / dst 51.
  - 60 beats total. No index reaches or exceeds 60.
- 8×8, CCW 90°:
  - The destination sequence equals the CW 270° run beat for beat. Beat 0 dst = 56.
- Backpressure on 8×8 0°:
  - Drop READY for 3 cycles at beat 5.
  - src/dst hold at 5 throughout the stall. No beat is skipped or duplicated (scoreboard over all 64).
- H=0, W=8:
  - O_DONE pulses in the cycle after I_START. O_VALID and O_BUSY stay 0.
- Reset mid-job:
  - Assert I_HRESET at beat 20 of an 8×8 90° job. Outputs go to 0 without waiting for a clock, and no O_DONE occurs.
  - A restart then produces beat 0 = src 0 / dst 7.
